alu_arbiter: RTL

// - Shares the single combinational 16-bit ALU between two requesters (fetch/decode unit = req0, debug/host port = req1).
// - Accepts one operation per grant over a valid/ready handshake and drives the ALU operand, op and enable inputs from registers.
// - Registers the ALU outputs and returns result, zero and carry with the requester ID over a valid/ready response channel.
// - Rejects ops the ALU cannot legally evaluate (divide/modulo by zero, undefined opcodes) and flags them with an error bit.
//

---
 rtl/hmmm_alu_pkg.sv | 30 +++
 rtl/alu_arbiter_rr_arb2.sv | 30 +++
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hmmm_alu_pkg.sv
// Shared definitions for the ALU sharing logic: opcode values, FSM encoding,
// default datapath widths and the opcode legality rule.
package hmmm_alu_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int OP_W_DEF  = 3;

   localparam int OP_ADD = 0;
   localparam int OP_SUB = 1;
   localparam int OP_MUL = 2;
   localparam int OP_DIV = 3;
   localparam int OP_MOD = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // An op is legal when the ALU defines it and it is not a division or
   // modulo by zero.
   function automatic logic op_is_legal(input int op, input logic b_zero);
      logic defined;
      logic by_zero;
      defined = (op >= OP_ADD) && (op <= OP_MOD);
      by_zero = ((op == OP_DIV) || (op == OP_MOD)) && b_zero;
      return defined && !by_zero;
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester that was not granted
// last wins; the pointer only moves when the parent commits a grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       grant_id
);

   // Id granted most recently; resets to 1 so req0 wins the first tie.
   logic last_reg;

   assign grant_id = (valid == 2'b11) ? ~last_reg : valid[1];

   for (genvar gi = 0; gi < 2; gi++) begin : g_grant
      assign grant[gi] = (|valid) && (grant_id == 1'(gi));
   end

   // Remember the committed grant for the next tie-break.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_reg <= 1'b1;
      end else if (advance) begin
         last_reg <= grant_id;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters. One op is accepted
// per grant, driven to the ALU for a single EXEC cycle, and the registered
// result is returned with the requester id over a valid/ready channel.
module alu_arbiter
   import hmmm_alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OP_W  = OP_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*OP_W-1:0]  req_op,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [WIDTH-1:0]   rsp_result,
   output logic               rsp_zero,
   output logic               rsp_carry,
   output logic               rsp_err,
   output logic [WIDTH-1:0]   alu_tmp1,
   output logic [WIDTH-1:0]   alu_tmp2,
   output logic [OP_W-1:0]    alu_op,
   output logic               alu_enable,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic               alu_zero,
   input  logic               alu_carry
);

   state_t state_reg;
   state_t state_next;

   logic [OP_W-1:0]  op_arr [2];
   logic [WIDTH-1:0] a_arr  [2];
   logic [WIDTH-1:0] b_arr  [2];

   logic [1:0]       grant;
   logic             grant_id;
   logic             accept;
   logic             op_legal;

   logic [OP_W-1:0]  op_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             id_reg;

   logic             rsp_id_reg;
   logic [WIDTH-1:0] rsp_result_reg;
   logic             rsp_zero_reg;
   logic             rsp_carry_reg;
   logic             rsp_err_reg;

   // Split the flat request buses into per-requester fields.
   for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign op_arr[gi] = req_op[gi*OP_W +: OP_W];
      assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
   end

   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    (req_valid),
      .advance  (accept),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign op_legal = op_is_legal(int'(op_reg), (b_reg == '0));

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state plus handshake and ALU enable; ready is forced low in reset
   // so an asserted valid cannot leak through while the FSM is held.
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      req_ready  = 2'b00;
      alu_enable = 1'b0;
      rsp_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rst_n && (|req_valid)) begin
               accept     = 1'b1;
               req_ready  = grant;
               state_next = EXEC;
            end
         end
         EXEC: begin
            alu_enable = op_legal;
            state_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Latch the granted request; these registers drive the ALU and hold
   // their value outside EXEC so the ALU inputs do not toggle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         id_reg <= 1'b0;
      end else if (accept) begin
         op_reg <= op_arr[grant_id];
         a_reg  <= a_arr[grant_id];
         b_reg  <= b_arr[grant_id];
         id_reg <= grant_id;
      end
   end

   // Capture the ALU outputs (or the fixed error response) at the end of EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_id_reg     <= 1'b0;
         rsp_result_reg <= '0;
         rsp_zero_reg   <= 1'b0;
         rsp_carry_reg  <= 1'b0;
         rsp_err_reg    <= 1'b0;
      end else if (state_reg == EXEC) begin
         rsp_id_reg <= id_reg;
         if (op_legal) begin
            rsp_result_reg <= alu_result;
            rsp_zero_reg   <= alu_zero;
            rsp_carry_reg  <= alu_carry;
            rsp_err_reg    <= 1'b0;
         end else begin
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b1;
            rsp_carry_reg  <= 1'b0;
            rsp_err_reg    <= 1'b1;
         end
      end
   end

   assign alu_tmp1   = a_reg;
   assign alu_tmp2   = b_reg;
   assign alu_op     = op_reg;
   assign rsp_id     = rsp_id_reg;
   assign rsp_result = rsp_result_reg;
   assign rsp_zero   = rsp_zero_reg;
   assign rsp_carry  = rsp_carry_reg;
   assign rsp_err    = rsp_err_reg;

endmodule
